// File: rtl/div_seq_pkg.sv
// Shared constants for the sequential divider: FSM encoding, request-op bit
// positions, iteration count and a two's-complement negate helper.
package div_seq_pkg;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam int OP_REM_BIT    = 0;
  localparam int OP_SIGNED_BIT = 1;

  localparam int         STEP_COUNT = 32;
  localparam logic [4:0] LAST_STEP  = 5'(STEP_COUNT - 1);

  function automatic logic [31:0] neg32(input logic [31:0] v);
    return (~v) + 32'd1;
  endfunction

endpackage

// File: rtl/div_seq_step.sv
// One restoring-division iteration: shift in the next dividend bit, then
// subtract the divisor when the 33-bit partial remainder covers it.
module div_seq_step (
  input  logic [31:0] rem,
  input  logic        dvd_msb,
  input  logic [31:0] divisor,
  output logic [31:0] rem_next,
  output logic        q_bit
);

  logic [32:0] shifted;
  logic [32:0] diff;

  assign shifted  = {rem, dvd_msb};
  assign diff     = shifted - {1'b0, divisor};
  assign q_bit    = (shifted >= {1'b0, divisor});
  assign rem_next = q_bit ? diff[31:0] : shifted[31:0];

endmodule

// File: rtl/div_seq_ctrl.sv
// EXE-stage divide sequencer: accept, 32 restoring steps, sign fix, hold until MEM takes it.
// Define DIV_SEQ_EARLY_OUT_EN to skip the iteration for zero divisors and |dividend| < |divisor|.
module div_seq_ctrl
  import div_seq_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [31:0] req_src1,
  input  logic [31:0] req_src2,
  input  logic        flush,
  input  logic        out_ready,
  output logic        out_valid,
  output logic [31:0] out_result,
  output logic        busy
);

  logic [1:0]  state;
  logic [4:0]  cnt;
  logic        op_rem;
  logic        neg_q;
  logic        neg_r;
  logic [31:0] dvd;
  logic [31:0] rem;
  logic [31:0] dsr;
  logic [31:0] rem_next;
  logic        q_bit;
  logic        is_signed;
  logic [31:0] abs1;
  logic [31:0] abs2;
  logic        accept;
  logic        early;
  logic [31:0] fix_q;
  logic [31:0] fix_r;

  assign is_signed = req_op[OP_SIGNED_BIT];
  assign abs1      = (is_signed && req_src1[31]) ? neg32(req_src1) : req_src1;
  assign abs2      = (is_signed && req_src2[31]) ? neg32(req_src2) : req_src2;
  assign accept    = (state == S_IDLE) && req_valid && !flush;

`ifdef DIV_SEQ_EARLY_OUT_EN
  assign early = (abs2 == 32'd0) || (abs1 < abs2);
`else
  assign early = 1'b0;
`endif

  assign req_ready = (state == S_IDLE);
  assign busy      = (state != S_IDLE);

  div_seq_step u_step (
    .rem      (rem),
    .dvd_msb  (dvd[31]),
    .divisor  (dsr),
    .rem_next (rem_next),
    .q_bit    (q_bit)
  );

  assign fix_q = neg_q ? neg32(dvd) : dvd;
  assign fix_r = neg_r ? neg32(rem) : rem;

  // Control: FSM, step counter, handshake and result register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      cnt        <= 5'd0;
      out_valid  <= 1'b0;
      out_result <= 32'd0;
    end else if (flush) begin
      state     <= S_IDLE;
      out_valid <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            cnt   <= 5'd0;
            state <= early ? S_FIX : S_CALC;
          end
        end
        S_CALC: begin
          cnt <= cnt + 5'd1;
          if (cnt == LAST_STEP) state <= S_FIX;
        end
        S_FIX: begin
          out_result <= op_rem ? fix_r : fix_q;
          state      <= S_DONE;
        end
        default: begin
          // out_valid rises one cycle into DONE, giving the fixed accept-to-valid latency
          if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            state     <= S_IDLE;
          end else begin
            out_valid <= 1'b1;
          end
        end
      endcase
    end
  end

  // Operand and iteration registers: dvd collects quotient bits as it shifts out dividend bits
  always_ff @(posedge clk) begin
    if (accept) begin
      op_rem <= req_op[OP_REM_BIT];
      neg_q  <= is_signed && (req_src1[31] ^ req_src2[31]);
      neg_r  <= is_signed && req_src1[31];
      dsr    <= abs2;
      if (early) begin
        dvd <= {32{abs2 == 32'd0}};
        rem <= abs1;
      end else begin
        dvd <= abs1;
        rem <= 32'd0;
      end
    end else if (state == S_CALC) begin
      dvd <= {dvd[30:0], q_bit};
      rem <= rem_next;
    end
  end

endmodule

// File: tb/tb_div_seq_ctrl.sv
// Directed bench for div_seq_ctrl; latency expectations follow DIV_SEQ_EARLY_OUT_EN.
`timescale 1ns/1ps
module tb_div_seq_ctrl;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [31:0] req_src1;
  logic [31:0] req_src2;
  logic        flush;
  logic        out_ready;
  logic        out_valid;
  logic [31:0] out_result;
  logic        busy;

  int checks = 0;
  int errors = 0;

`ifdef DIV_SEQ_EARLY_OUT_EN
  localparam int EARLY_LAT = 2;
`else
  localparam int EARLY_LAT = 34;
`endif
  localparam int FULL_LAT = 34;

  div_seq_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_src1   (req_src1),
    .req_src2   (req_src2),
    .flush      (flush),
    .out_ready  (out_ready),
    .out_valid  (out_valid),
    .out_result (out_result),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Presents one request for the accept edge; afterwards we sit 1ns past that edge.
  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    req_op    = op;
    req_src1  = a;
    req_src2  = b;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  // Counts edges after the accept edge until out_valid appears (bounded).
  task automatic wait_valid(output int lat);
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic handoff();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (req_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0 || out_result !== 32'd0) begin
      errors++;
      $display("FAIL reset_state ready=%b busy=%b valid=%b result=%h required 1 0 0 00000000",
               req_ready, busy, out_valid, out_result);
    end
    reset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_ops();
    logic [1:0]  ops  [9] = '{2'b10, 2'b11, 2'b11, 2'b00, 2'b01, 2'b00, 2'b01, 2'b10, 2'b11};
    logic [31:0] as   [9] = '{32'd7, 32'd7, 32'hFFFFFFF9, 32'hFFFFFFFF, 32'hFFFFFFFF,
                              32'd5, 32'd5, 32'h80000000, 32'h80000000};
    logic [31:0] bs   [9] = '{32'hFFFFFFFE, 32'hFFFFFFFE, 32'd2, 32'h10, 32'h10,
                              32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF};
    logic [31:0] exps [9] = '{32'hFFFFFFFD, 32'd1, 32'hFFFFFFFF, 32'h0FFFFFFF, 32'h0000000F,
                              32'hFFFFFFFF, 32'd5, 32'h80000000, 32'd0};
    int          lats [9] = '{FULL_LAT, FULL_LAT, FULL_LAT, FULL_LAT, FULL_LAT,
                              EARLY_LAT, EARLY_LAT, FULL_LAT, FULL_LAT};
    int lat;
    for (int i = 0; i < 9; i++) begin
      issue(ops[i], as[i], bs[i]);
      wait_valid(lat);
      checks++;
      if (lat !== lats[i]) begin
        errors++;
        $display("FAIL op%0d_latency got %0d required %0d", i, lat, lats[i]);
      end
      checks++;
      if (out_result !== exps[i]) begin
        errors++;
        $display("FAIL op%0d_result got %h required %h", i, out_result, exps[i]);
      end
      handoff();
      checks++;
      if (req_ready !== 1'b1 || out_valid !== 1'b0) begin
        errors++;
        $display("FAIL op%0d_handoff ready=%b valid=%b required 1 0", i, req_ready, out_valid);
      end
    end
  endtask

  task automatic test_hold();
    int lat;
    issue(2'b00, 32'd1000, 32'd10);
    wait_valid(lat);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || req_ready !== 1'b0 || out_result !== 32'd100) begin
        errors++;
        $display("FAIL hold_cycle%0d valid=%b ready=%b result=%h required 1 0 00000064",
                 i, out_valid, req_ready, out_result);
      end
    end
    handoff();
    checks++;
    if (req_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL hold_release ready=%b busy=%b required 1 0", req_ready, busy);
    end
  endtask

  task automatic test_flush();
    int lat;
    issue(2'b00, 32'd100, 32'd7);
    repeat (10) @(posedge clk);
    #1;
    flush     = 1'b1;
    req_valid = 1'b1;
    req_src1  = 32'd50;
    req_src2  = 32'd5;
    @(posedge clk); #1;
    flush     = 1'b0;
    req_valid = 1'b0;
    checks++;
    if (busy !== 1'b0 || req_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_idle busy=%b ready=%b valid=%b required 0 1 0", busy, req_ready, out_valid);
    end
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL flush_req_ignored busy=%b required 0", busy);
    end
    issue(2'b00, 32'd100, 32'd7);
    wait_valid(lat);
    checks++;
    if (lat !== FULL_LAT || out_result !== 32'd14) begin
      errors++;
      $display("FAIL flush_rerun latency=%0d result=%h required %0d 0000000e", lat, out_result, FULL_LAT);
    end
    handoff();
  endtask

  task automatic test_back_to_back();
    int lat;
    issue(2'b00, 32'd100, 32'd7);
    wait_valid(lat);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    issue(2'b01, 32'd100, 32'd7);
    wait_valid(lat);
    checks++;
    if (lat !== FULL_LAT || out_result !== 32'd2) begin
      errors++;
      $display("FAIL back_to_back latency=%0d result=%h required %0d 00000002", lat, out_result, FULL_LAT);
    end
    handoff();
  endtask

  task automatic test_reset_mid();
    issue(2'b00, 32'd100, 32'd7);
    repeat (5) @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || out_result !== 32'd0 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid busy=%b valid=%b result=%h ready=%b required 0 0 00000000 1",
               busy, out_valid, out_result, req_ready);
    end
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_early_out();
    int lat;
    issue(2'b00, 32'd3, 32'd9);
    wait_valid(lat);
    checks++;
    if (lat !== EARLY_LAT || out_result !== 32'd0) begin
      errors++;
      $display("FAIL early_out latency=%0d result=%h required %0d 00000000", lat, out_result, EARLY_LAT);
    end
    handoff();
  endtask

  initial begin
    reset     = 1'b0;
    req_valid = 1'b0;
    req_op    = 2'b00;
    req_src1  = 32'd0;
    req_src2  = 32'd0;
    flush     = 1'b0;
    out_ready = 1'b0;
    test_reset();
    test_ops();
    test_hold();
    test_flush();
    test_back_to_back();
    test_reset_mid();
    test_early_out();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
